datapath_mc: RTL

- Parametrised multicycle successor of the single-cycle 8-bit datapath.
- Owns its own FETCH/DECODE/EXEC sequencer, so no external control unit is used.
- Adds conditional branches, HALT, an explicit load/run handshake, and configurable data and code widths.
- Sits at top level below the board wrapper; code memory is loaded through the code_* port before run.

---
 rtl/datapath_mc_pkg.sv | 32 +++
 rtl/datapath_mc_regfile.sv | 33 +++
 rtl/datapath_mc.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/datapath_mc_pkg.sv
// Shared constants for datapath_mc: opcodes, ALU sub-ops, flag bit positions and FSM states.
package datapath_mc_pkg;

    localparam logic [4:0] OP_MOVI = 5'b01000;
    localparam logic [4:0] OP_MOVF = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_JZ   = 5'b10001;
    localparam logic [4:0] OP_JNZ  = 5'b10010;
    localparam logic [4:0] OP_JC   = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // ALU instructions are opcode 00ooo; these are the ooo values
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_FETCH  = 3'b001;
    localparam logic [2:0] ST_DECODE = 3'b010;
    localparam logic [2:0] ST_EXEC   = 3'b011;
    localparam logic [2:0] ST_HALTED = 3'b100;

endpackage

// File: rtl/datapath_mc_regfile.sv
// dmc_regfile: 8 x DATA_W register file, two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
module dmc_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr_a,
    input  logic [2:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-edge value, so rd==ra instructions use the old operand
    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/datapath_mc.sv
// datapath_mc: multicycle FETCH/DECODE/EXEC core with on-chip code memory.
// Optional retired-instruction counter enabled by defining DATAPATH_MC_PERF_EN.
module datapath_mc
    import datapath_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              code_w_en,
    input  logic [ADDR_W-1:0] code_addr_in,
    input  logic [15:0]       code_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              halted,
    output logic [DATA_W-1:0] debug,
    output logic [31:0]       retired
);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_maddr;
    logic [15:0]       r_ir;
    logic [2:0]        r_flags;
    logic [DATA_W-1:0] r_debug;
    logic [15:0]       r_mem [2**ADDR_W];

    logic [4:0]        w_opcode;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_wr_en;
    logic              w_flag_we;
    logic              w_branch;
    logic [2:0]        w_flags_nxt;
    logic              w_code_we;
    logic              w_exec;

    assign w_opcode  = r_ir[15:11];
    assign w_exec    = (r_state == ST_EXEC);
    // Loads are only accepted while the core is parked; elsewhere they are silently dropped
    assign w_code_we = code_w_en && ((r_state == ST_IDLE) || (r_state == ST_HALTED));

    always_ff @(posedge clk) begin
        if (w_code_we) begin
            r_mem[code_addr_in] <= code_in;
        end
        if (r_state == ST_DECODE) begin
            r_ir <= r_mem[r_maddr];
        end
    end

    dmc_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_exec && w_wr_en),
        .i_waddr   (r_ir[10:8]),
        .i_wdata   (w_result),
        .i_raddr_a (r_ir[5:3]),
        .i_raddr_b (r_ir[2:0]),
        .o_rdata_a (w_a),
        .o_rdata_b (w_b)
    );

    // Extra msb captures carry-out for ADD and borrow for SUB
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_result  = '0;
        w_carry   = 1'b0;
        w_wr_en   = 1'b0;
        w_flag_we = 1'b0;
        w_branch  = 1'b0;
        if (w_opcode[4:3] == 2'b00) begin
            w_wr_en   = 1'b1;
            w_flag_we = 1'b1;
            case (w_opcode[2:0])
                ALU_ADD: {w_carry, w_result} = w_sum;
                ALU_SUB: {w_carry, w_result} = w_diff;
                ALU_AND: w_result = w_a & w_b;
                ALU_OR:  w_result = w_a | w_b;
                ALU_XOR: w_result = w_a ^ w_b;
                ALU_NOT: w_result = ~w_a;
                ALU_SHL: begin
                    w_result = {w_a[DATA_W-2:0], 1'b0};
                    w_carry  = w_a[DATA_W-1];
                end
                default: begin
                    w_result = {1'b0, w_a[DATA_W-1:1]};
                    w_carry  = w_a[0];
                end
            endcase
        end else begin
            case (w_opcode)
                OP_MOVI: begin
                    w_wr_en  = 1'b1;
                    w_result = DATA_W'(r_ir[7:0]);
                end
                OP_MOVF: begin
                    w_wr_en  = 1'b1;
                    w_result = DATA_W'({r_flags[FLAG_N], r_flags[FLAG_C], r_flags[FLAG_Z]});
                end
                OP_JMP:  w_branch = 1'b1;
                OP_JZ:   w_branch = r_flags[FLAG_Z];
                OP_JNZ:  w_branch = !r_flags[FLAG_Z];
                OP_JC:   w_branch = r_flags[FLAG_C];
                default: w_branch = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_flags_nxt         = '0;
        w_flags_nxt[FLAG_Z] = (w_result == '0);
        w_flags_nxt[FLAG_C] = w_carry;
        w_flags_nxt[FLAG_N] = w_result[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_maddr <= '0;
            r_flags <= '0;
            r_debug <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run && !code_w_en) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_maddr <= r_pc;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_wr_en) begin
                        r_debug <= w_result;
                    end
                    if (w_flag_we) begin
                        r_flags <= w_flags_nxt;
                    end
                    if (w_branch) begin
                        r_pc <= r_ir[ADDR_W-1:0];
                    end
                    if (w_opcode == OP_HALT) begin
                        r_state <= ST_HALTED;
                    end else if (run) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    if (!run) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DATAPATH_MC_PERF_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_exec && (r_retired != 32'hFFFF_FFFF)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

    assign pc_out = r_pc;
    assign busy   = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);
    assign halted = (r_state == ST_HALTED);
    assign debug  = r_debug;

endmodule
